sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
// - Two-requester arbiter in front of one pipelined sram_controller (memctrl_* interface).
// - Port 0 = message-block fetch, port 1 = hash-state write-back/readback; both share one SRAM.
// - Issues at most one access per cycle, tracks read ownership, routes dat_ready/data back.
// PARAMETERS
// - ADDR_WIDTH    3   SRAM word address width
// - DATA_WIDTH    32  SRAM word width
// - READ_LATENCY  2   cycles from issued read (memctrl_enable & !memctrl_rw) to dat_ready; >=1
// PORTS
// - clock               in   1    single clock, rising edge
// - reset               in   1    asynchronous, active-low
// - req0/req1           in   1    access request, held until granted
// - lock0/lock1         in   1    keep ownership after grant (burst); sampled with reqN
// - rw0/rw1             in   1    1 = write, 0 = read
// - addr0/addr1         in   ADDR_WIDTH  word address
// - wdata0/wdata1       in   DATA_WIDTH  write data
// - gnt0/gnt1           out  1    request accepted this cycle (combinational)
// - rvalid0/rvalid1     out  1    read data valid for that port (registered)
// - rdata0/rdata1       out  DATA_WIDTH  read data (registered, holds last value)
// - memctrl_enable      out  1    to controller: access this cycle
// - memctrl_rw          out  1    to controller: 1 = write
// - memctrl_addr        out  ADDR_WIDTH  to controller
// - memctrl_write_data  out  DATA_WIDTH  to controller
// - dat_ready           in   1    from controller: read data valid
// - memctrl_out_data    in   DATA_WIDTH  from controller
// - arb_err             out  1    sticky: dat_ready with no read outstanding
// BEHAVIOUR
// - Reset: gnt*=0, rvalid*=0, rdata*=0, memctrl_enable=0, memctrl_rw=0, addr/wdata=0, arb_err=0,
//   FSM=IDLE, rr_last=1 (port 0 wins first tie), tag pipe cleared. Mid-burst reset drops lock
//   and all outstanding reads; no rvalid after reset release for pre-reset reads.
// - FSM: IDLE -> OWN0/OWN1 when granted request has lockN=1; OWNn -> IDLE on cycle owner
//   presents reqN with lockN=0 (that access is granted) or owner drops reqN (no grant).
// - IDLE arbitration: single request wins; both -> port != rr_last; rr_last updates on grant.
// - OWNn: only port n granted; other port stalls (gnt=0) regardless of round robin.
// - gntN=1 => memctrl_* driven from port N same cycle, memctrl_enable=1; no grant => enable=0.
// - Throughput: one grant per cycle, back-to-back grants to same/different ports allowed.
// - Tag pipe: READ_LATENCY-deep shift of {is_read, port}; push on every cycle (bubble if none).
//   On dat_ready: if tail.is_read, next edge rvalid[port]=1, rdata[port]=memctrl_out_data;
//   else arb_err<=1 (sticky until reset), data dropped. rvalid is one-cycle pulse.
// - Read latency seen by requester = READ_LATENCY+1 cycles from gnt.
// - Writes produce no response; read-after-write same addr ordered by issue order.
// CONFIGURATION
// - SRAM_ARB_FIXED_PRIO_EN defined: IDLE arbitration fixed, port 0 always beats port 1;
//   rr_last unused. Lock/OWN states unchanged (lock still blocks port 0 during OWN1).
// - Undefined (default): round-robin as above.
// TESTING
// - reset=0 mid-run -> all outputs 0 within same cycle; arb_err cleared; no stale rvalid.
// - req0 read addr 1 only -> gnt0=1 cycle 0, memctrl_addr=1, rvalid0=1 with SRAM[1] at cycle 3.
// - req0&req1 reads every cycle, addr0=2, addr1=5 -> grants alternate 0,1,0,1; rvalid0/1
//   alternate with SRAM[2]/SRAM[5], never swapped.
// - req1 lock1=1 write 0x56789ABC addr 3 then 3 more words, req0 held -> gnt0=0 for 4 cycles,
//   port0 granted cycle after lock1 drops; port0 read addr 3 returns 0x56789ABC.
// - Force dat_ready=1 with no read outstanding -> arb_err=1 next edge, stays 1, no rvalid.
// - SRAM_ARB_FIXED_PRIO_EN: both req continuous, no lock -> gnt0 every cycle, gnt1 never.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of one pipelined SRAM controller
// Optional: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 over port 1) in IDLE.
module sram_arbiter #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic                  rw0,
    input  logic                  rw1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  memctrl_enable,
    output logic                  memctrl_rw,
    output logic [ADDR_WIDTH-1:0] memctrl_addr,
    output logic [DATA_WIDTH-1:0] memctrl_write_data,
    input  logic                  dat_ready,
    input  logic [DATA_WIDTH-1:0] memctrl_out_data,
    output logic                  arb_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_prefer0;
    logic [READ_LATENCY-1:0] r_tag_rd;
    logic [READ_LATENCY-1:0] r_tag_port;
    logic                    w_push_rd;
    logic                    w_tail_rd;
    logic                    w_tail_port;
    logic                    w_rsp0;
    logic                    w_rsp1;
    logic                    r_rvalid0;
    logic                    r_rvalid1;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;
    logic                    r_arb_err;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_prefer0 = 1'b1;
`else
    logic r_rr_last;

    // Tie goes to whichever port was not granted most recently.
    assign w_prefer0 = r_rr_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_last <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            r_rr_last <= w_gnt1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_gnt0 = w_prefer0;
                    w_gnt1 = !w_prefer0;
                end else begin
                    w_gnt0 = req0;
                    w_gnt1 = req1;
                end
                if (w_gnt0 && lock0) begin
                    w_state_nxt = ST_OWN0;
                end else if (w_gnt1 && lock1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                w_gnt0 = req0;
                if (!req0 || !lock0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN1: begin
                w_gnt1 = req1;
                if (!req1 || !lock1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Reset forces the combinational grant path low within the same cycle.
        if (!reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign gnt0               = w_gnt0;
    assign gnt1               = w_gnt1;
    assign memctrl_enable     = w_gnt0 | w_gnt1;
    assign memctrl_rw         = w_gnt0 ? rw0 : (w_gnt1 ? rw1 : 1'b0);
    assign memctrl_addr       = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);
    assign memctrl_write_data = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

    assign w_push_rd   = memctrl_enable & !memctrl_rw;
    assign w_tail_rd   = r_tag_rd[READ_LATENCY-1];
    assign w_tail_port = r_tag_port[READ_LATENCY-1];
    assign w_rsp0      = dat_ready & w_tail_rd & !w_tail_port;
    assign w_rsp1      = dat_ready & w_tail_rd & w_tail_port;

    // One tag per cycle, bubbles included, so the tail lines up with dat_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_rd   <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_rd[0]   <= w_push_rd;
            r_tag_port[0] <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_rd[i]   <= r_tag_rd[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_rvalid0 <= w_rsp0;
            r_rvalid1 <= w_rsp1;
            if (w_rsp0) begin
                r_rdata0 <= memctrl_out_data;
            end
            if (w_rsp1) begin
                r_rdata1 <= memctrl_out_data;
            end
            if (dat_ready && !w_tail_rd) begin
                r_arb_err <= 1'b1;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign arb_err = r_arb_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and randomized checks of sram_arbiter against a reference model
module tb_sram_arbiter;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1, lock0, lock1, rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          memctrl_enable, memctrl_rw;
    logic [AW-1:0] memctrl_addr;
    logic [DW-1:0] memctrl_write_data;
    logic          dat_ready;
    logic [DW-1:0] memctrl_out_data;
    logic          arb_err;

    always #5 clock = ~clock;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memctrl_enable(memctrl_enable), .memctrl_rw(memctrl_rw),
        .memctrl_addr(memctrl_addr), .memctrl_write_data(memctrl_write_data),
        .dat_ready(dat_ready), .memctrl_out_data(memctrl_out_data),
        .arb_err(arb_err)
    );

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    // SRAM controller environment: reacts to what the DUT actually issues.
    logic [DW-1:0] env_mem [8];
    rsp_t          env_q [$];
    bit            force_dr;
    // Reference model: owner of the SRAM, last winner, memory, expected responses.
    logic [DW-1:0] ref_mem [8];
    rsp_t          ref_q [$];
    int            owner;
    int            last_win;
    int            g_eg;
    logic          exp_rv0, exp_rv1, exp_err;
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            cyc;
    int            n_vec;
    int            n_mis;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        last_win = 1;
        exp_rv0  = 0; exp_rv1 = 0; exp_err = 0;
        exp_rd0  = '0; exp_rd1 = '0;
        ref_q.delete();
        env_q.delete();
    endtask

    task automatic check_regs();
        chk("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rv0});
        chk("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rv1});
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
        chk("arb_err", {31'd0, arb_err}, {31'd0, exp_err});
    endtask

    // One clock cycle: check the combinational grant path, play the SRAM, advance the model.
    task automatic tick();
        logic          w_rw;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic          w_lock;
        bit            real_dr;
        rsp_t          r;
        #1;
        g_eg = -1;
        if (reset) begin
            if (owner == -1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                if (req0) g_eg = 0;
                else if (req1) g_eg = 1;
`else
                if (req0 && req1) g_eg = (last_win == 1) ? 0 : 1;
                else if (req0) g_eg = 0;
                else if (req1) g_eg = 1;
`endif
            end else if (owner == 0) begin
                g_eg = req0 ? 0 : -1;
            end else begin
                g_eg = req1 ? 1 : -1;
            end
        end
        w_rw   = (g_eg == 0) ? rw0 : rw1;
        w_addr = (g_eg == 0) ? addr0 : addr1;
        w_data = (g_eg == 0) ? wdata0 : wdata1;
        w_lock = (g_eg == 0) ? lock0 : lock1;
        chk("gnt0", {31'd0, gnt0}, {31'd0, (g_eg == 0)});
        chk("gnt1", {31'd0, gnt1}, {31'd0, (g_eg == 1)});
        chk("enable", {31'd0, memctrl_enable}, {31'd0, (g_eg >= 0)});
        if (g_eg >= 0) begin
            chk("mc_rw", {31'd0, memctrl_rw}, {31'd0, w_rw});
            chk("mc_addr", {29'd0, memctrl_addr}, {29'd0, w_addr});
            if (w_rw) chk("mc_wdata", memctrl_write_data, w_data);
        end
        real_dr = (env_q.size() > 0) && (env_q[0].due == cyc);
        dat_ready        = real_dr || force_dr;
        memctrl_out_data = real_dr ? env_q[0].data : $urandom;
        if (memctrl_enable) begin
            if (memctrl_rw) env_mem[memctrl_addr] = memctrl_write_data;
            else env_q.push_back('{cyc + RL, 0, env_mem[memctrl_addr]});
        end
        @(posedge clock);
        exp_rv0 = 0;
        exp_rv1 = 0;
        if (dat_ready) begin
            if (ref_q.size() > 0 && ref_q[0].due == cyc) begin
                r = ref_q.pop_front();
                if (r.port == 0) begin exp_rv0 = 1; exp_rd0 = r.data; end
                else begin exp_rv1 = 1; exp_rd1 = r.data; end
            end else begin
                exp_err = 1;
            end
        end
        if (g_eg >= 0) begin
            if (w_rw) ref_mem[w_addr] = w_data;
            else ref_q.push_back('{cyc + RL, g_eg, ref_mem[w_addr]});
            last_win = g_eg;
        end
        if (owner == -1) begin
            if (g_eg >= 0 && w_lock) owner = g_eg;
        end else if (owner == 0) begin
            if (!req0 || !lock0) owner = -1;
        end else begin
            if (!req1 || !lock1) owner = -1;
        end
        if (real_dr) void'(env_q.pop_front());
        cyc++;
        #1;
        check_regs();
    endtask

    task automatic set_port(input int p, input logic rq, input logic lk, input logic rw,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = rq; lock0 = lk; rw0 = rw; addr0 = a; wdata0 = d; end
        else begin req1 = rq; lock1 = lk; rw1 = rw; addr1 = a; wdata1 = d; end
    endtask

    task automatic idle(input int n);
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_vec = 0; n_mis = 0; cyc = 0; force_dr = 0;
        dat_ready = 0; memctrl_out_data = '0;
        for (int i = 0; i < 8; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        reset = 0;
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        model_reset();
        #2;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_enable", {31'd0, memctrl_enable}, 32'd0);
        check_regs();
        tick();
        reset = 1;

        // Single read from port 0, address 1.
        set_port(0, 1, 0, 0, 3'd1, '0);
        tick();
        idle(4);

        // Both ports read continuously; grants alternate under round robin.
        set_port(0, 1, 0, 0, 3'd2, '0);
        set_port(1, 1, 0, 0, 3'd5, '0);
        for (int i = 0; i < 8; i++) tick();
        idle(4);

        // Port 1 burst-writes four words under lock while port 0 waits to read address 3.
        set_port(1, 1, 1, 1, 3'd3, 32'h56789ABC);
        tick();
        set_port(0, 1, 0, 0, 3'd3, '0);
        set_port(1, 1, 1, 1, 3'd4, 32'h11111111);
        tick();
        set_port(1, 1, 1, 1, 3'd5, 32'h22222222);
        tick();
        set_port(1, 1, 0, 1, 3'd6, 32'h33333333);
        tick();
        set_port(1, 0, 0, 0, '0, '0);
        tick();
        set_port(0, 0, 0, 0, '0, '0);
        idle(4);
        chk("burst_rdback", rdata0, 32'h56789ABC);

        // Spurious dat_ready with nothing outstanding.
        force_dr = 1;
        tick();
        force_dr = 0;
        idle(3);

        // Reset in the middle of a locked burst with reads in flight.
        set_port(0, 1, 1, 0, 3'd2, '0);
        set_port(1, 1, 0, 0, 3'd5, '0);
        tick();
        tick();
        #2;
        reset = 0;
        #1;
        chk("mrst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("mrst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("mrst_enable", {31'd0, memctrl_enable}, 32'd0);
        model_reset();
        check_regs();
        tick();
        tick();
        reset = 1;
        idle(4);

        // Randomized traffic; a request is held unchanged until it is granted.
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || g_eg == 0 || !req0)
                set_port(0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            if (i == 0 || g_eg == 1 || !req1)
                set_port(1, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            tick();
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
